// File: rtl/strobe_divider_frac_if.sv
// Strobe/config bundle for the fractional strobe divider; master drives strobes and config, slave divides.
interface strobe_divider_frac_if #(
   parameter int WIDTH      = 7,
   parameter int FRAC_WIDTH = 8
);
   logic                  strobe_in;
   logic                  strobe_out;
   logic [WIDTH-1:0]      R_in;
   logic [FRAC_WIDTH-1:0] F_in;
   logic                  cfg_load;
   logic                  cfg_pending;
   logic                  sync;

   modport master (
      output strobe_in, R_in, F_in, cfg_load, sync,
      input  strobe_out, cfg_pending
   );

   modport slave (
      input  strobe_in, R_in, F_in, cfg_load, sync,
      output strobe_out, cfg_pending
   );
endinterface

// File: rtl/strobe_divider_frac.sv
// Fractional-N strobe divider (R / R+1 dual modulus), strobe_out 1 clock after the period-ending strobe_in, no backpressure.
// Define STROBE_DIV_PHASE_OUT_EN to expose phase_cycle / phase_acc / period_last for downstream phase alignment.
module strobe_divider_frac #(
   parameter int          WIDTH      = 7,
   parameter int          FRAC_WIDTH = 8,
   parameter int unsigned DEFAULT_R  = 1,
   parameter int unsigned DEFAULT_F  = 0
) (
   input  logic                   clock,
   input  logic                   reset_n,
   strobe_divider_frac_if.slave   bus
`ifdef STROBE_DIV_PHASE_OUT_EN
   ,
   output logic [WIDTH-1:0]       phase_cycle,
   output logic [FRAC_WIDTH-1:0]  phase_acc,
   output logic                   period_last
`endif
);

   logic [WIDTH-1:0]      cycle_q,  cycle_d;
   logic [WIDTH-1:0]      r_act_q,  r_act_d;
   logic [WIDTH-1:0]      r_pend_q, r_pend_d;
   logic [FRAC_WIDTH-1:0] acc_q,    acc_d;
   logic [FRAC_WIDTH-1:0] f_act_q,  f_act_d;
   logic [FRAC_WIDTH-1:0] f_pend_q, f_pend_d;
   logic                  carry_q,      carry_d;
   logic                  strobe_out_q, strobe_out_d;
   logic                  pend_vld_q,   pend_vld_d;

   logic                  halted;
   logic [WIDTH:0]        period_len;
   logic                  last_w;
   logic [FRAC_WIDTH:0]   acc_sum;
   logic                  nxt_vld;
   logic [WIDTH-1:0]      r_nxt;
   logic [FRAC_WIDTH-1:0] f_nxt;

   assign halted     = (r_act_q == '0);
   // One extra bit so R=2^WIDTH-1 plus a carry gives a 2^WIDTH period instead of wrapping.
   assign period_len = {1'b0, r_act_q} + {{WIDTH{1'b0}}, carry_q};
   assign last_w     = !halted && ({1'b0, cycle_q} == (period_len - (WIDTH+1)'(1)));
   assign acc_sum    = {1'b0, acc_q} + {1'b0, f_act_q};

   // A coincident cfg_load takes precedence over the stored shadow whenever config is applied this cycle.
   assign nxt_vld = bus.cfg_load | pend_vld_q;
   assign r_nxt   = bus.cfg_load ? bus.R_in : r_pend_q;
   assign f_nxt   = bus.cfg_load ? bus.F_in : f_pend_q;

   always_comb begin
      cycle_d      = cycle_q;
      r_act_d      = r_act_q;
      r_pend_d     = r_pend_q;
      acc_d        = acc_q;
      f_act_d      = f_act_q;
      f_pend_d     = f_pend_q;
      carry_d      = carry_q;
      strobe_out_d = 1'b0;
      pend_vld_d   = pend_vld_q;

      if (bus.sync) begin
         cycle_d    = '0;
         acc_d      = '0;
         carry_d    = 1'b0;
         pend_vld_d = 1'b0;
         if (nxt_vld) begin
            r_act_d = r_nxt;
            f_act_d = f_nxt;
         end
      end else if (halted) begin
         // Only an already-registered shadow is applied; a fresh load waits one cycle.
         if (pend_vld_q) begin
            r_act_d    = r_pend_q;
            f_act_d    = f_pend_q;
            pend_vld_d = 1'b0;
         end
         if (bus.cfg_load) begin
            r_pend_d   = bus.R_in;
            f_pend_d   = bus.F_in;
            pend_vld_d = 1'b1;
         end
      end else if (bus.strobe_in && last_w) begin
         strobe_out_d = 1'b1;
         cycle_d      = '0;
         carry_d      = acc_sum[FRAC_WIDTH];
         acc_d        = acc_sum[FRAC_WIDTH-1:0];
         pend_vld_d   = 1'b0;
         if (nxt_vld) begin
            r_act_d = r_nxt;
            f_act_d = f_nxt;
         end
      end else begin
         if (bus.strobe_in) begin
            cycle_d = cycle_q + WIDTH'(1);
         end
         if (bus.cfg_load) begin
            r_pend_d   = bus.R_in;
            f_pend_d   = bus.F_in;
            pend_vld_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cycle_q      <= '0;
         r_act_q      <= WIDTH'(DEFAULT_R);
         r_pend_q     <= '0;
         acc_q        <= '0;
         f_act_q      <= FRAC_WIDTH'(DEFAULT_F);
         f_pend_q     <= '0;
         carry_q      <= 1'b0;
         strobe_out_q <= 1'b0;
         pend_vld_q   <= 1'b0;
      end else begin
         cycle_q      <= cycle_d;
         r_act_q      <= r_act_d;
         r_pend_q     <= r_pend_d;
         acc_q        <= acc_d;
         f_act_q      <= f_act_d;
         f_pend_q     <= f_pend_d;
         carry_q      <= carry_d;
         strobe_out_q <= strobe_out_d;
         pend_vld_q   <= pend_vld_d;
      end
   end

   assign bus.strobe_out  = strobe_out_q;
   assign bus.cfg_pending = pend_vld_q;

`ifdef STROBE_DIV_PHASE_OUT_EN
   assign phase_cycle = cycle_q;
   assign phase_acc   = acc_q;
   assign period_last = last_w;
`endif

endmodule

// File: tb/tb_strobe_divider_frac.sv
// Bench for strobe_divider_frac: two instances (FRAC_WIDTH 8 and 4) driven identically, checked against a period-level model.
module tb_strobe_divider_frac;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   strobe_divider_frac_if #(.WIDTH(7), .FRAC_WIDTH(8)) b0 ();
   strobe_divider_frac_if #(.WIDTH(7), .FRAC_WIDTH(4)) b1 ();

`ifdef STROBE_DIV_PHASE_OUT_EN
   logic [6:0] pc0, pc1;
   logic [7:0] pa0;
   logic [3:0] pa1;
   logic       pl0, pl1;
`endif

   strobe_divider_frac #(.WIDTH(7), .FRAC_WIDTH(8), .DEFAULT_R(1), .DEFAULT_F(0)) u0 (
      .clock(clock), .reset_n(reset_n), .bus(b0)
`ifdef STROBE_DIV_PHASE_OUT_EN
      , .phase_cycle(pc0), .phase_acc(pa0), .period_last(pl0)
`endif
   );

   strobe_divider_frac #(.WIDTH(7), .FRAC_WIDTH(4), .DEFAULT_R(1), .DEFAULT_F(0)) u1 (
      .clock(clock), .reset_n(reset_n), .bus(b1)
`ifdef STROBE_DIV_PHASE_OUT_EN
      , .phase_cycle(pc1), .phase_acc(pa1), .period_last(pl1)
`endif
   );

   logic [1:0] so, cp;
   assign so = {b1.strobe_out, b0.strobe_out};
   assign cp = {b1.cfg_pending, b0.cfg_pending};

   int total = 0;
   int bad   = 0;

   // Reference state: strobes counted in the current period, period length is r + carry.
   int m_fw[2] = '{8, 4};
   int m_r[2], m_f[2], m_acc[2], m_carry[2], m_cnt[2], m_pr[2], m_pf[2];
   bit m_pv[2], m_out[2];

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_r[k] = 1; m_f[k] = 0; m_acc[k] = 0; m_carry[k] = 0; m_cnt[k] = 0;
         m_pr[k] = 0; m_pf[k] = 0; m_pv[k] = 1'b0; m_out[k] = 1'b0;
      end
   endtask

   task automatic model_step(input int k, input bit s, input bit ld, input int rin, input int fin, input bit sy);
      int modv, rv, fv, sum;
      modv = 1 << m_fw[k];
      rv = rin % 128;
      fv = fin % modv;
      m_out[k] = 1'b0;
      if (sy) begin
         m_cnt[k] = 0; m_acc[k] = 0; m_carry[k] = 0;
         if (ld) begin m_r[k] = rv; m_f[k] = fv; end
         else if (m_pv[k]) begin m_r[k] = m_pr[k]; m_f[k] = m_pf[k]; end
         m_pv[k] = 1'b0;
      end else if (m_r[k] == 0) begin
         if (m_pv[k]) begin m_r[k] = m_pr[k]; m_f[k] = m_pf[k]; m_pv[k] = 1'b0; end
         if (ld) begin m_pr[k] = rv; m_pf[k] = fv; m_pv[k] = 1'b1; end
      end else if (s && (m_cnt[k] + 1 == m_r[k] + m_carry[k])) begin
         m_out[k] = 1'b1;
         m_cnt[k] = 0;
         sum = m_acc[k] + m_f[k];
         m_carry[k] = (sum >= modv) ? 1 : 0;
         m_acc[k] = sum % modv;
         if (ld) begin m_r[k] = rv; m_f[k] = fv; end
         else if (m_pv[k]) begin m_r[k] = m_pr[k]; m_f[k] = m_pf[k]; end
         m_pv[k] = 1'b0;
      end else begin
         if (s) m_cnt[k] = m_cnt[k] + 1;
         if (ld) begin m_pr[k] = rv; m_pf[k] = fv; m_pv[k] = 1'b1; end
      end
   endtask

   // Drives one clock of stimulus on both DUTs and advances the reference; returns #1 after the edge.
   task automatic step(input bit s, input bit ld, input int rin, input int fin, input bit sy);
      logic [7:0] fbits;
      fbits = 8'(fin);
      @(negedge clock);
      b0.strobe_in = s;  b1.strobe_in = s;
      b0.cfg_load  = ld; b1.cfg_load  = ld;
      b0.sync      = sy; b1.sync      = sy;
      b0.R_in = 7'(rin); b1.R_in = 7'(rin);
      b0.F_in = fbits;   b1.F_in = fbits[3:0];
      for (int k = 0; k < 2; k++) model_step(k, s, ld, rin, fin, sy);
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n = 1'b0;
      b0.strobe_in = 0; b1.strobe_in = 0; b0.cfg_load = 0; b1.cfg_load = 0;
      b0.sync = 0; b1.sync = 0; b0.R_in = '0; b1.R_in = '0; b0.F_in = '0; b1.F_in = '0;
      model_reset();
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      for (int k = 0; k < 2; k++) begin
         total++;
         if (so[k] !== 1'b0 || cp[k] !== 1'b0) begin
            bad++;
            $display("FAIL reset_state dut%0d strobe_out=%0b cfg_pending=%0b expected 0/0", k, so[k], cp[k]);
         end
      end
   endtask

   task automatic test_default_div1();
      int run = 0;
      for (int i = 0; i < 10; i++) begin
         step(1, 0, 0, 0, 0);
         if (so[0] === 1'b1) run++;
         total++;
         if (so !== {m_out[1], m_out[0]}) begin
            bad++;
            $display("FAIL div1_cycle%0d got=%b exp=%b%b", i, so, m_out[1], m_out[0]);
         end
      end
      step(0, 0, 0, 0, 0);
      total++;
      if (run != 10 || so[0] !== 1'b0) begin
         bad++;
         $display("FAIL div1_run high_cycles=%0d tail=%0b expected 10 then 0", run, so[0]);
      end
   endtask

   task automatic test_int5();
      int outs = 0;
      step(0, 1, 5, 0, 0);
      total++;
      if (cp !== 2'b11) begin bad++; $display("FAIL int5_pending_set got=%b exp=11", cp); end
      step(0, 0, 0, 0, 1);
      total++;
      if (cp !== 2'b00) begin bad++; $display("FAIL int5_pending_clr got=%b exp=00", cp); end
      for (int i = 0; i < 60; i++) begin
         step(i[0] == 1'b0, 0, 0, 0, 0);
         if (so[0] === 1'b1) begin
            outs++;
            total++;
            if ((i / 2) % 5 != 4 || i[0] != 1'b0) begin
               bad++;
               $display("FAIL int5_phase strobe_out at cycle %0d expected after strobe 5k", i);
            end
         end
         total++;
         if (so !== {m_out[1], m_out[0]}) begin bad++; $display("FAIL int5_cycle%0d got=%b exp=%b%b", i, so, m_out[1], m_out[0]); end
      end
      total++;
      if (outs != 6) begin bad++; $display("FAIL int5_count got=%0d exp=6", outs); end
   endtask

   task automatic test_frac();
      int exp_len[5] = '{3, 3, 4, 3, 4};
      int lens[$];
      int n = 0, last = 0;
      step(0, 1, 3, 8, 0);
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 49; i++) begin
         step(i < 48, 0, 0, 0, 0);
         if (i < 48) n++;
         if (so[1] === 1'b1) begin lens.push_back(n - last); last = n; end
         total++;
         if (so !== {m_out[1], m_out[0]}) begin bad++; $display("FAIL frac_cycle%0d got=%b exp=%b%b", i, so, m_out[1], m_out[0]); end
      end
      total++;
      if (lens.size() != 14) begin bad++; $display("FAIL frac_count got=%0d exp=14", lens.size()); end
      for (int j = 0; j < 5; j++) begin
         total++;
         if (j >= lens.size() || lens[j] != exp_len[j]) begin
            bad++;
            $display("FAIL frac_len%0d got=%0d exp=%0d", j, (j < lens.size()) ? lens[j] : -1, exp_len[j]);
         end
      end
   endtask

   task automatic test_midcfg();
      step(0, 1, 6, 0, 0);
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
      step(0, 1, 2, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 0, 0);
         total++;
         if (so !== ((i == 2) ? 2'b11 : 2'b00) || cp !== ((i == 2) ? 2'b00 : 2'b11)) begin
            bad++;
            $display("FAIL midcfg_old_period strobe%0d strobe_out=%b cfg_pending=%b", i + 4, so, cp);
         end
      end
      for (int i = 0; i < 6; i++) begin
         step(1, 0, 0, 0, 0);
         total++;
         if (so !== (i[0] ? 2'b11 : 2'b00)) begin bad++; $display("FAIL midcfg_new_period%0d got=%b exp=%b", i, so, i[0] ? 2'b11 : 2'b00); end
      end
   endtask

   task automatic test_halt();
      int outs = 0;
      int l0[$], l1[$];
      int n = 0, a0 = 0, a1 = 0;
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 20; i++) begin
         step(1, 0, 0, 0, 0);
         total++;
         if (so !== 2'b00) begin bad++; $display("FAIL halt_quiet%0d got=%b exp=00", i, so); end
      end
      step(0, 1, 4, 0, 0);
      total++;
      if (cp !== 2'b11) begin bad++; $display("FAIL halt_load_pending got=%b exp=11", cp); end
      step(0, 0, 0, 0, 0);
      total++;
      if (cp !== 2'b00) begin bad++; $display("FAIL halt_apply got=%b exp=00", cp); end
      for (int i = 0; i < 20; i++) begin
         step(1, 0, 0, 0, 0);
         if (so[0] === 1'b1) outs++;
      end
      total++;
      if (outs != 5) begin bad++; $display("FAIL halt_resume_count got=%0d exp=5", outs); end
      step(0, 1, 127, 255, 0);
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 384; i++) begin
         step(1, 0, 0, 0, 0);
         n++;
         if (so[0] === 1'b1) begin l0.push_back(n - a0); a0 = n; end
         if (so[1] === 1'b1) begin l1.push_back(n - a1); a1 = n; end
      end
      total++;
      if (l0.size() < 3 || l0[0] != 127 || l0[1] != 127 || l0[2] != 128) begin
         bad++;
         $display("FAIL long_period_f8 periods=%0d first=%0d third=%0d exp 127,127,128", l0.size(), (l0.size() > 0) ? l0[0] : -1, (l0.size() > 2) ? l0[2] : -1);
      end
      total++;
      if (l1.size() < 3 || l1[0] != 127 || l1[1] != 127 || l1[2] != 128) begin
         bad++;
         $display("FAIL long_period_f4 periods=%0d first=%0d third=%0d exp 127,127,128", l1.size(), (l1.size() > 0) ? l1[0] : -1, (l1.size() > 2) ? l1[2] : -1);
      end
   endtask

   task automatic test_sync_coincident();
      step(0, 1, 4, 5, 0);
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
      step(1, 1, 2, 3, 1);
      total++;
      if (so !== 2'b00 || cp !== 2'b00) begin bad++; $display("FAIL sync_coincident strobe_out=%b cfg_pending=%b exp 00/00", so, cp); end
`ifdef STROBE_DIV_PHASE_OUT_EN
      total++;
      if (pc0 !== 7'd0 || pa0 !== 8'd0 || pc1 !== 7'd0 || pa1 !== 4'd0) begin
         bad++;
         $display("FAIL sync_phase cycle=%0d/%0d acc=%0d/%0d exp 0", pc0, pc1, pa0, pa1);
      end
`endif
      step(1, 0, 0, 0, 0);
      total++;
      if (so !== 2'b00) begin bad++; $display("FAIL sync_newcfg_first got=%b exp=00", so); end
      step(1, 0, 0, 0, 0);
      total++;
      if (so !== 2'b11) begin bad++; $display("FAIL sync_newcfg_second got=%b exp=11", so); end
   endtask

   task automatic test_reset_mid();
      step(0, 1, 5, 0, 0);
      step(0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0);
      step(1, 1, 7, 0, 0);
      #2 reset_n = 1'b0;
      #1;
      total++;
      if (so !== 2'b00 || cp !== 2'b00) begin bad++; $display("FAIL reset_mid_pending strobe_out=%b cfg_pending=%b exp 00/00", so, cp); end
      do_reset();
      step(1, 0, 0, 0, 0);
      total++;
      if (so !== 2'b11) begin bad++; $display("FAIL reset_default_ratio got=%b exp=11", so); end
      #2 reset_n = 1'b0;
      #1;
      total++;
      if (so !== 2'b00) begin bad++; $display("FAIL reset_kills_strobe got=%b exp=00", so); end
      do_reset();
   endtask

   task automatic test_random();
      bit s, ld, sy;
      int rin, fin;
      for (int i = 0; i < 3000; i++) begin
         s   = ($urandom_range(0, 3) != 0);
         ld  = ($urandom_range(0, 19) == 0);
         sy  = ($urandom_range(0, 39) == 0);
         rin = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 7);
         fin = $urandom_range(0, 255);
         step(s, ld, rin, fin, sy);
         total++;
         if (so !== {m_out[1], m_out[0]} || cp !== {m_pv[1], m_pv[0]}) begin
            bad++;
            $display("FAIL random_cycle%0d strobe_out=%b cfg_pending=%b exp=%b%b/%b%b", i, so, cp, m_out[1], m_out[0], m_pv[1], m_pv[0]);
         end
`ifdef STROBE_DIV_PHASE_OUT_EN
         total++;
         if (int'(pc0) != m_cnt[0] || int'(pa0) != m_acc[0] || int'(pc1) != m_cnt[1] || int'(pa1) != m_acc[1] ||
             pl0 !== (m_r[0] != 0 && m_cnt[0] + 1 == m_r[0] + m_carry[0]) ||
             pl1 !== (m_r[1] != 0 && m_cnt[1] + 1 == m_r[1] + m_carry[1])) begin
            bad++;
            $display("FAIL random_phase%0d cycle=%0d/%0d acc=%0d/%0d exp cycle=%0d/%0d acc=%0d/%0d", i, pc0, pc1, pa0, pa1, m_cnt[0], m_cnt[1], m_acc[0], m_acc[1]);
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_default_div1();
      test_int5();
      test_frac();
      test_midcfg();
      test_halt();
      test_sync_coincident();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
